// File: rtl/daq_pkg.sv
// -----------------------------------------------------------------------------
// daq_pkg
// Shared definitions for the DAQ channel datapath: default bus widths and the
// SRAM writer FSM encoding. Reused by the channel, the SRAM writer and the
// Wishbone register block so every consumer agrees on widths and state codes.
// -----------------------------------------------------------------------------
package daq_pkg;

  // Default widths: channel data word, SRAM word address, word counter.
  localparam int DAQ_DW = 32;
  localparam int DAQ_AW = 16;
  localparam int DAQ_CW = 16;

  // SRAM writer FSM. The encoding is fixed so software-visible status bits
  // (busy = ST_WRITE) read the same everywhere.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } daq_wr_state_e;

endpackage : daq_pkg

// File: rtl/daq_ring_ptr.sv
// -----------------------------------------------------------------------------
// daq_ring_ptr
// Circular-buffer offset tracker. Holds the next offset inside a buffer of
// buf_words entries and a sticky "has wrapped" flag. Written generically so
// the reader side of the buffer can reuse it unchanged.
//
//   advance : step the pointer by one slot (wrap to 0 at the last slot)
//   clear   : zero pointer and wrapped flag; wins over advance
//
// buf_words is sampled when advancing, so a new length takes effect on the
// next advance. A length of 0 behaves as a one-slot buffer, and a pointer that
// already sits at or beyond the last slot of a shrunk buffer wraps to 0.
// -----------------------------------------------------------------------------
module daq_ring_ptr #(
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [cw-1:0] buf_words,
  output logic [cw-1:0] wr_ptr,
  output logic          wrapped
);

  logic at_last;

  // Last slot of the current buffer, treating a zero length as one slot.
  always_comb begin
    at_last = (buf_words == '0) || (wr_ptr >= (buf_words - cw'(1)));
  end

  // Pointer and sticky wrap flag; clear has priority over advance.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      wrapped <= 1'b0;
    end else if (advance) begin
      if (at_last) begin
        wr_ptr  <= '0;
        wrapped <= 1'b1;
      end else begin
        wr_ptr  <= wr_ptr + cw'(1);
      end
    end
  end

endmodule : daq_ring_ptr

// File: rtl/daq_sram_writer.sv
// -----------------------------------------------------------------------------
// daq_sram_writer
// Downstream stage of a DAQ channel. Each start_sram strobe (with enable high
// and the writer idle) captures one data word and writes it into a circular
// buffer in SRAM through a req/ack port. Tracks the write pointer, a
// saturating word count, and sticky wrapped/overflow flags for software.
//
// Flow:  strobe -> (1 cycle) sram_req/busy high, addr/data held -> sram_ack
//        -> pointer and count update, back to idle; next strobe accepted the
//        cycle after ack. Strobes that cannot be accepted (busy, including the
//        ack cycle, or enable low) drop the word and set overflow.
//
// clear is applied at once when idle; during a write it is remembered and
// applied on the ack cycle, taking priority over that cycle's increment.
//
// Build option: define DAQ_SRAM_WRITER_IRQ_EN to build the half/full irq
// pulse for ping-pong draining; otherwise irq is tied to 0.
// -----------------------------------------------------------------------------
module daq_sram_writer
  import daq_pkg::*;
#(
  parameter int dw = DAQ_DW,
  parameter int aw = DAQ_AW,
  parameter int cw = DAQ_CW
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          enable,
  input  logic          clear,
  input  logic          start_sram,
  input  logic [dw-1:0] data_in,
  input  logic [aw-1:0] base_addr,
  input  logic [cw-1:0] buf_words,
  output logic          sram_req,
  output logic [aw-1:0] sram_addr,
  output logic [dw-1:0] sram_data,
  input  logic          sram_ack,
  output logic          busy,
  output logic [cw-1:0] wr_ptr,
  output logic [cw-1:0] word_count,
  output logic          wrapped,
  output logic          overflow,
  output logic          irq
);

  daq_wr_state_e state, state_nxt;

  logic          accept;      // strobe taken this cycle
  logic          ack_fire;    // write completes this cycle
  logic          clear_pend;  // clear seen during a write, not yet applied
  logic          ring_clear;  // zero pointer, count and sticky flags now
  logic [cw-1:0] addr_ptr;    // offset used for the captured address

  assign accept   = (state == ST_IDLE) && start_sram && enable;
  assign ack_fire = (state == ST_WRITE) && sram_ack;

  // Idle clears act immediately; write-time clears land on the ack.
  assign ring_clear = ((state == ST_IDLE) && clear) ||
                      (ack_fire && (clear || clear_pend));

  // A same-cycle idle clear means the captured word goes to offset 0.
  assign addr_ptr = clear ? '0 : wr_ptr;

  // FSM state register.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt = state;
    sram_req  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        sram_req = 1'b1;
        busy     = 1'b1;
        if (sram_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture address and data on accept; held stable for the whole write.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      sram_addr <= '0;
      sram_data <= '0;
    end else if (accept) begin
      sram_addr <= base_addr + aw'(addr_ptr);
      sram_data <= data_in;
    end
  end

  // Remember a clear that arrives while a write is in flight.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      clear_pend <= 1'b0;
    end else if (ack_fire) begin
      clear_pend <= 1'b0;
    end else if ((state == ST_WRITE) && clear) begin
      clear_pend <= 1'b1;
    end
  end

  // Saturating count of completed writes since the last clear.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      word_count <= '0;
    end else if (ring_clear) begin
      word_count <= '0;
    end else if (ack_fire && (word_count != '1)) begin
      word_count <= word_count + cw'(1);
    end
  end

  // Sticky overflow: any strobe that was not accepted drops its word.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      overflow <= 1'b0;
    end else if (ring_clear) begin
      overflow <= 1'b0;
    end else if (start_sram && !accept) begin
      overflow <= 1'b1;
    end
  end

  // Buffer offset and wrap tracking.
  daq_ring_ptr #(
    .cw (cw)
  ) u_ring_ptr (
    .clk       (wb_clk),
    .rst_n     (wb_rst),
    .clear     (ring_clear),
    .advance   (ack_fire),
    .buf_words (buf_words),
    .wr_ptr    (wr_ptr),
    .wrapped   (wrapped)
  );

`ifdef DAQ_SRAM_WRITER_IRQ_EN
  logic irq_hit;

  // The ack writes offset wr_ptr; flag it when that is the half-full slot
  // (buf_words/2-1) or the last slot. Lengths 0 and 1 hit on every ack.
  always_comb begin
    irq_hit = (buf_words == '0) || (wr_ptr >= (buf_words - cw'(1)));
    if ((buf_words >= cw'(2)) && (wr_ptr == ((buf_words >> 1) - cw'(1)))) begin
      irq_hit = 1'b1;
    end
  end

  // One-cycle irq pulse following a qualifying ack.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ack_fire && irq_hit;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule : daq_sram_writer
